// File: rtl/kamus_pkg.sv
// ============================================================================
//  kamus_pkg
//  Shared widths, writeback-select encoding and MEM/WB payload for kamus.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package kamus_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic [RADDR_W-1:0]  rd;
    wb_sel_e             sel;
    logic [XLEN-1:0]     ex_rslt;
    logic [XLEN-1:0]     ld_data;
    logic [XLEN-1:0]     pc4;
    logic [XLEN-1:0]     imm;
  } memwb_t;

endpackage

`default_nettype wire

// File: rtl/kamus_memwb_reg.sv
// ============================================================================
//  kamus_memwb_reg
//  MEM/WB pipeline register; flush beats stall, stall beats capture.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module kamus_memwb_reg
  import kamus_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   stall_i,
  input  logic   flush_i,
  input  memwb_t memwb_i,
  output memwb_t memwb_o
);

  memwb_t memwb_q;
  memwb_t memwb_d;

  always_comb begin
    memwb_d = memwb_q;
    if (flush_i) begin
      // Payload is left untouched on a flush; only the valid bit matters.
      memwb_d.valid = 1'b0;
    end else if (!stall_i) begin
      memwb_d = memwb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign memwb_o = memwb_q;

endmodule

`default_nettype wire

// File: rtl/kamus_wb.sv
// ============================================================================
//  kamus_wb
//  Writeback stage: MEM/WB register, writeback mux, regfile/forward drive and
//  retire pulse. Optional retire counter enabled by KAMUS_WB_INSTRET_EN.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module kamus_wb #(
  parameter int XLEN      = kamus_pkg::XLEN,
  parameter int RADDR_W   = kamus_pkg::RADDR_W,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 regfile_wr_en_i,
  input  logic [XLEN-1:0]      ex_rslt_i,
  input  logic [XLEN-1:0]      l1d_rd_data_i,
  input  logic [XLEN-1:0]      pc_plus4_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [1:0]           wb_mux_sel_i,
  input  logic [RADDR_W-1:0]   rd_addr_i,
  output logic                 rf_wr_en_o,
  output logic [RADDR_W-1:0]   rf_wr_addr_o,
  output logic [XLEN-1:0]      rf_wr_data_o,
  output logic                 fwd_valid_o,
  output logic [RADDR_W-1:0]   fwd_rd_addr_o,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic                 retire_o,
  output logic [INSTRET_W-1:0] instret_o
);

  import kamus_pkg::*;

  memwb_t          memwb_in;
  memwb_t          memwb_q;
  logic [XLEN-1:0] wb_data;
  logic            wb_wr_en;

  always_comb begin
    memwb_in         = '0;
    memwb_in.valid   = valid_i;
    memwb_in.wr_en   = regfile_wr_en_i;
    memwb_in.rd      = rd_addr_i;
    memwb_in.sel     = wb_sel_e'(wb_mux_sel_i);
    memwb_in.ex_rslt = ex_rslt_i;
    memwb_in.ld_data = l1d_rd_data_i;
    memwb_in.pc4     = pc_plus4_i;
    memwb_in.imm     = imm_i;
  end

  kamus_memwb_reg u_memwb_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .memwb_i (memwb_in),
    .memwb_o (memwb_q)
  );

  always_comb begin
    wb_data = memwb_q.ex_rslt;
    case (memwb_q.sel)
      WB_ALU:  wb_data = memwb_q.ex_rslt;
      WB_MEM:  wb_data = memwb_q.ld_data;
      WB_PC4:  wb_data = memwb_q.pc4;
      WB_IMM:  wb_data = memwb_q.imm;
      default: wb_data = memwb_q.ex_rslt;
    endcase
  end

  // x0 is hard-wired zero, so it never produces a write or a forward.
  assign wb_wr_en      = memwb_q.valid & memwb_q.wr_en & (|memwb_q.rd);

  assign rf_wr_en_o    = wb_wr_en;
  assign rf_wr_addr_o  = memwb_q.rd;
  assign rf_wr_data_o  = wb_data;
  assign fwd_valid_o   = wb_wr_en;
  assign fwd_rd_addr_o = memwb_q.rd;
  assign fwd_data_o    = wb_data;

  // A held instruction retires only on the cycle it is finally released.
  assign retire_o      = memwb_q.valid & ~stall_i;

`ifdef KAMUS_WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;
  logic [INSTRET_W-1:0] instret_d;

  always_comb begin
    instret_d = instret_q;
    if (retire_o) begin
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kamus_wb.sv
// ============================================================================
//  tb_kamus_wb
//  Directed self-checking bench for the kamus writeback stage.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kamus_wb;

  import kamus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        stall;
  logic        flush;
  logic        wr_en;
  logic [31:0] ex_rslt;
  logic [31:0] ld_data;
  logic [31:0] pc4;
  logic [31:0] imm;
  logic [1:0]  sel;
  logic [4:0]  rd;

  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_data;
  logic        retire;
  logic [63:0] instret;

  int checks;
  int errors;

  kamus_wb dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .valid_i         (valid),
    .stall_i         (stall),
    .flush_i         (flush),
    .regfile_wr_en_i (wr_en),
    .ex_rslt_i       (ex_rslt),
    .l1d_rd_data_i   (ld_data),
    .pc_plus4_i      (pc4),
    .imm_i           (imm),
    .wb_mux_sel_i    (sel),
    .rd_addr_i       (rd),
    .rf_wr_en_o      (rf_wr_en),
    .rf_wr_addr_o    (rf_wr_addr),
    .rf_wr_data_o    (rf_wr_data),
    .fwd_valid_o     (fwd_valid),
    .fwd_rd_addr_o   (fwd_rd_addr),
    .fwd_data_o      (fwd_data),
    .retire_o        (retire),
    .instret_o       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic we, input logic [4:0] r,
                        input logic [1:0] s, input logic [31:0] e,
                        input logic [31:0] l, input logic [31:0] p,
                        input logic [31:0] i);
    valid = v; wr_en = we; rd = r; sel = s;
    ex_rslt = e; ld_data = l; pc4 = p; imm = i;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rf_wr_en, fwd_valid, retire, rf_wr_addr, rf_wr_data, instret} !== '0) begin
      errors++;
      $display("FAIL reset_initial: en=%b fv=%b ret=%b addr=%0d data=%h instret=%h expected all 0",
               rf_wr_en, fwd_valid, retire, rf_wr_addr, rf_wr_data, instret);
    end
    tick();
    rst_n = 1'b1;
    tick();
    set_in(1'b1, 1'b1, 5'd9, WB_ALU, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    valid = 1'b1; wr_en = 1'b1; rd = 5'd10; ex_rslt = 32'h1111_2222;
    checks++;
    if (rf_wr_en !== 1'b1 || rf_wr_data !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL reset_preload: en=%b data=%h expected 1/cafe0001", rf_wr_en, rf_wr_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_wr_en, fwd_valid, retire, rf_wr_addr, rf_wr_data, instret} !== '0) begin
      errors++;
      $display("FAIL reset_midstream: en=%b fv=%b ret=%b addr=%0d data=%h instret=%h expected all 0",
               rf_wr_en, fwd_valid, retire, rf_wr_addr, rf_wr_data, instret);
    end
    tick();
    idle();
    checks++;
    if (rf_wr_en !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: en=%b ret=%b expected 0/0", rf_wr_en, retire);
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_wb();
    set_in(1'b1, 1'b1, 5'd5, WB_ALU, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    checks++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h0000_1234 || retire !== 1'b1) begin
      errors++;
      $display("FAIL alu_wb: en=%b addr=%0d data=%h ret=%b expected 1/5/00001234/1",
               rf_wr_en, rf_wr_addr, rf_wr_data, retire);
    end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd_addr !== 5'd5 || fwd_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL alu_fwd: fv=%b addr=%0d data=%h expected 1/5/00001234",
               fwd_valid, fwd_rd_addr, fwd_data);
    end
    tick();
    checks++;
    if (rf_wr_en !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL alu_drain: en=%b ret=%b expected 0/0", rf_wr_en, retire);
    end
  endtask

  task automatic test_mux_sweep();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'hA; exp_data[1] = 32'hB; exp_data[2] = 32'hC; exp_data[3] = 32'hD;
    for (int s = 0; s < 4; s++) begin
      set_in(1'b1, 1'b1, 5'd3, 2'(s), 32'hA, 32'hB, 32'hC, 32'hD);
      tick();
      idle();
      checks++;
      if (rf_wr_data !== exp_data[s] || fwd_data !== exp_data[s]) begin
        errors++;
        $display("FAIL mux_sel%0d: rf=%h fwd=%h expected %h", s, rf_wr_data, fwd_data, exp_data[s]);
      end
    end
  endtask

  task automatic test_x0_guard();
    set_in(1'b1, 1'b1, 5'd0, WB_ALU, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    checks++;
    if (rf_wr_en !== 1'b0 || fwd_valid !== 1'b0 || retire !== 1'b1) begin
      errors++;
      $display("FAIL x0_guard: en=%b fv=%b ret=%b expected 0/0/1", rf_wr_en, fwd_valid, retire);
    end
    set_in(1'b1, 1'b0, 5'd4, WB_ALU, 32'h1, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    checks++;
    if (rf_wr_en !== 1'b0 || retire !== 1'b1) begin
      errors++;
      $display("FAIL no_wr_en: en=%b ret=%b expected 0/1", rf_wr_en, retire);
    end
  endtask

  task automatic test_stall_flush();
    set_in(1'b1, 1'b1, 5'd7, WB_MEM, 32'h0, 32'h55, 32'h0, 32'h0);
    tick();
    // New MEM payload is presented while stalled; it must not be captured.
    set_in(1'b1, 1'b1, 5'd8, WB_ALU, 32'h99, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      stall = (c < 3);
      #1;
      checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h55 || retire !== (c == 3)) begin
        errors++;
        $display("FAIL stall_c%0d: en=%b addr=%0d data=%h ret=%b expected 1/7/00000055/%b",
                 c, rf_wr_en, rf_wr_addr, rf_wr_data, retire, (c == 3));
      end
      if (c < 3) tick();
    end
    tick();
    checks++;
    if (rf_wr_addr !== 5'd8 || rf_wr_data !== 32'h99) begin
      errors++;
      $display("FAIL stall_release: addr=%0d data=%h expected 8/00000099", rf_wr_addr, rf_wr_data);
    end
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    #1;
    checks++;
    if (rf_wr_en !== 1'b0 || fwd_valid !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: en=%b fv=%b ret=%b expected 0/0/0", rf_wr_en, fwd_valid, retire);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int k = 1; k <= 3; k++) begin
      d = 32'h100 * k;
      set_in(1'b1, 1'b1, 5'(k + 10), WB_IMM, 32'h0, 32'h0, 32'h0, d);
      tick();
      checks++;
      if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'(k + 10) || rf_wr_data !== d) begin
        errors++;
        $display("FAIL b2b_%0d: en=%b addr=%0d data=%h expected 1/%0d/%h",
                 k, rf_wr_en, rf_wr_addr, rf_wr_data, k + 10, d);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_instret();
`ifdef KAMUS_WB_INSTRET_EN
    logic [63:0] exp_cnt [3];
    exp_cnt[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_cnt[1] = 64'h0;
    exp_cnt[2] = 64'h1;
    idle();
    tick();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    set_in(1'b1, 1'b1, 5'd1, WB_ALU, 32'h1, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL instret_preload: got %h expected fffffffffffffffe", instret);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) idle();
      tick();
      checks++;
      if (instret !== exp_cnt[k]) begin
        errors++;
        $display("FAIL instret_step%0d: got %h expected %h", k, instret, exp_cnt[k]);
      end
    end
`else
    set_in(1'b1, 1'b1, 5'd1, WB_ALU, 32'h1, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    idle();
    tick();
    checks++;
    if (instret !== 64'h0) begin
      errors++;
      $display("FAIL instret_off: got %h expected 0", instret);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_alu_wb();
    test_mux_sweep();
    test_x0_guard();
    test_stall_flush();
    test_back_to_back();
    test_instret();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
